// File: rtl/alu_defs_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU core.
package alu_defs;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_single_op(input logic [3:0] op);
        return (op == OP_AND) || (op == OP_OR)  || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_SLT) || (op == OP_NOR);
    endfunction

endpackage

// File: rtl/alu_bitslice.sv
// 1-bit ALU cell: optional operand inversion, AND/OR/SUM/LESS select, ripple carry.
module alu_bitslice (
    input  logic       a,
    input  logic       b,
    input  logic       ainv,
    input  logic       binv,
    input  logic [1:0] op,
    input  logic       cin,
    input  logic       less,
    output logic       cout,
    output logic       o,
    output logic       set,
    output logic       ovf
);

    logic w_a;
    logic w_b;
    logic w_sum;

    always_comb begin
        w_a   = a ^ ainv;
        w_b   = b ^ binv;
        w_sum = w_a ^ w_b ^ cin;
        cout  = (w_a & w_b) | (w_a & cin) | (w_b & cin);
        ovf   = cin ^ cout;
        // Only meaningful at the MSB: sign of the difference corrected for overflow.
        set   = w_sum ^ ovf;
        unique case (op)
            2'b00:   o = w_a & w_b;
            2'b01:   o = w_a | w_b;
            2'b10:   o = w_sum;
            default: o = less;
        endcase
    end

endmodule

// File: rtl/alu_seq_core.sv
// WIDTH-bit ALU with registered result, valid/ready handshakes and an iterative shift-add multiplier.
module alu_seq_core
    import alu_defs::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_zero,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_err
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_t              r_state;
    state_t              w_state_next;
    logic [WIDTH-1:0]    r_mul_a;
    logic [WIDTH-1:0]    r_mul_b;
    logic [2*WIDTH-1:0]  r_acc;
    logic [CW-1:0]       r_cnt;

    logic                r_valid;
    logic [WIDTH-1:0]    r_res;
    logic                r_zero;
    logic                r_cout;
    logic                r_ovf;
    logic                r_err;

    logic [WIDTH:0]      w_c;
    logic [WIDTH-1:0]    w_o;
    logic [WIDTH-1:0]    w_set;
    logic [WIDTH-1:0]    w_ovf;

    logic                w_accept;
    logic                w_mul_go;
    logic [WIDTH-1:0]    w_res;
    logic                w_cout;
    logic                w_ovf_flag;
    logic                w_err;

    assign w_c[0] = in_op[2];

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        alu_bitslice u_slice (
            .a    (in_a[i]),
            .b    (in_b[i]),
            .ainv (in_op[3]),
            .binv (in_op[2]),
            .op   (in_op[1:0]),
            .cin  (w_c[i]),
            .less ((i == 0) ? w_set[WIDTH-1] : 1'b0),
            .cout (w_c[i+1]),
            .o    (w_o[i]),
            .set  (w_set[i]),
            .ovf  (w_ovf[i])
        );
    end

    assign w_accept = in_valid & in_ready;
    assign w_mul_go = MUL_EN && (in_op == OP_MUL);

    always_comb begin
        w_res      = '0;
        w_cout     = 1'b0;
        w_ovf_flag = 1'b0;
        w_err      = 1'b0;
        if (is_single_op(in_op)) begin
            w_res = w_o;
            if (in_op == OP_ADD || in_op == OP_SUB) begin
                w_cout     = w_c[WIDTH];
                w_ovf_flag = w_ovf[WIDTH-1];
            end else if (in_op == OP_SLT) begin
                w_cout = w_c[WIDTH];
            end
        end else begin
            w_err = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept && w_mul_go) w_state_next = ST_MUL;
            ST_MUL:  if (r_cnt == CW'(WIDTH-1)) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = rst_n && (r_state == ST_IDLE) && (!r_valid || out_ready);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mul_a <= '0;
            r_mul_b <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_res   <= '0;
            r_zero  <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept && w_mul_go) begin
                r_mul_a <= in_a;
                r_mul_b <= in_b;
                r_acc   <= '0;
                r_cnt   <= '0;
            end else if (r_state == ST_MUL) begin
                if (r_mul_b[r_cnt])
                    r_acc <= r_acc + ({{WIDTH{1'b0}}, r_mul_a} << r_cnt);
                r_cnt <= r_cnt + CW'(1);
            end

            // A MUL accept falls through to the pop branch so the previous result retires.
            if (w_accept && !w_mul_go) begin
                r_valid <= 1'b1;
                r_res   <= w_res;
                r_zero  <= (w_res == '0);
                r_cout  <= w_cout;
                r_ovf   <= w_ovf_flag;
                r_err   <= w_err;
            end else if (r_state == ST_DONE) begin
                r_valid <= 1'b1;
                r_res   <= r_acc[WIDTH-1:0];
                r_zero  <= (r_acc[WIDTH-1:0] == '0);
                r_cout  <= 1'b0;
                r_ovf   <= |r_acc[2*WIDTH-1:WIDTH];
                r_err   <= 1'b0;
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_res   = r_res;
    assign out_zero  = r_zero;
    assign out_cout  = r_cout;
    assign out_ovf   = r_ovf;
    assign out_err   = r_err;

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed and streaming checks of alu_seq_core against an arithmetic reference model and result queue.
module tb_alu_seq_core;
    import alu_defs::*;

    localparam int unsigned W = 64;

    typedef struct packed {
        logic [W-1:0] res;
        logic         zero;
        logic         cout;
        logic         ovf;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [3:0]   in_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_res;
    logic         out_zero;
    logic         out_cout;
    logic         out_ovf;
    logic         out_err;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned n_got = 0;
    int unsigned cyc   = 0;

    alu_seq_core #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_zero  (out_zero),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t          e;
        logic [W:0]    s;
        logic [2*W-1:0] p;
        e = '0;
        case (op)
            OP_AND: e.res = a & b;
            OP_OR:  e.res = a | b;
            OP_NOR: e.res = ~(a | b);
            OP_ADD: begin
                s      = {1'b0, a} + {1'b0, b};
                e.res  = s[W-1:0];
                e.cout = s[W];
                e.ovf  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
            end
            OP_SUB: begin
                e.res  = a - b;
                e.cout = (a >= b);
                e.ovf  = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            OP_SLT: begin
                e.res  = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
                e.cout = (a >= b);
            end
            OP_MUL: begin
                p     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.res = p[W-1:0];
                e.ovf = |p[2*W-1:W];
            end
            default: e.err = 1'b1;
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    // Scoreboard: compare every result the consumer takes against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            chk("sb_has_entry", 128'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("res",  out_res,  e.res);
                chk("zero", out_zero, e.zero);
                chk("cout", out_cout, e.cout);
                chk("ovf",  out_ovf,  e.ovf);
                chk("err",  out_err,  e.err);
                n_got++;
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned waited = 0;
        logic        ok;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            waited++;
        end while (!ok && waited < 200);
        chk("accept", ok, 1);
        if (ok) sb.push_back(model(op, a, b));
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b0, {(W-1){1'b1}}};
            3:       v = {1'b1, {(W-1){1'b0}}};
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    initial begin
        int unsigned  lat;
        logic         busy_bad;
        int unsigned  c0;
        int unsigned  g0;
        exp_t         held;
        logic [3:0]   ops[8];
        logic [W-1:0] a;
        logic [W-1:0] b;

        ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, 4'b0100, 4'b1010};
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_res",   out_res,   0);
        chk("rst_out_zero",  out_zero,  0);
        chk("rst_flags",     {out_cout, out_ovf, out_err}, 0);
        chk("rst_in_ready",  in_ready,  0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        send(OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1);
        idle();
        chk("add_latency", out_valid, 1);
        send(OP_SUB, 64'd5, 64'd5);
        send(OP_SLT, '1, 64'd1);
        send(OP_SLT, 64'd1, '1);
        send(OP_NOR, 64'h00FF_00FF_0000_FFFF, 64'h0F0F_0000_F0F0_0000);
        send(4'b1111, 64'h1234, 64'h5678);
        idle();
        repeat (2) @(posedge clk);
        #1;

        send(OP_MUL, 64'd12, 64'd10);
        idle();
        lat = 0;
        busy_bad = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) busy_bad = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        chk("mul_latency", lat, W + 1);
        chk("mul_in_ready_low", busy_bad, 0);

        @(posedge clk);
        #1;
        send(OP_MUL, 64'h1_0000_0000, 64'h1_0000_0000);
        idle();
        lat = 0;
        busy_bad = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) busy_bad = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        chk("mul2_latency", lat, W + 1);
        chk("mul2_in_ready_low", busy_bad, 0);
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        send(OP_AND, 64'hF0F0_1234_5678_9ABC, 64'h0FF0_FFFF_0000_FFFF);
        idle();
        held = model(OP_AND, 64'hF0F0_1234_5678_9ABC, 64'h0FF0_FFFF_0000_FFFF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid",    out_valid, 1);
            chk("bp_res",      out_res,   held.res);
            chk("bp_zero",     out_zero,  held.zero);
            chk("bp_in_ready", in_ready,  0);
        end
        out_ready = 1'b1;
        send(OP_OR, 64'h1, 64'h8000_0000_0000_0000);
        idle();
        chk("handoff_valid", out_valid, 1);
        @(posedge clk);
        #1;

        send(OP_MUL, 64'd3, 64'd7);
        idle();
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midmul_rst_valid", out_valid, 0);
        chk("midmul_rst_ready", in_ready,  0);
        sb.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midmul_rel_ready", in_ready,  1);
        chk("midmul_rel_valid", out_valid, 0);
        g0 = n_got;
        repeat (W + 10) @(posedge clk);
        #1;
        chk("midmul_no_result", n_got - g0, 0);

        c0 = cyc;
        g0 = n_got;
        for (int k = 0; k < 1000; k++) begin
            a = rand_operand();
            b = rand_operand();
            send(ops[$urandom_range(0, 7)], a, b);
        end
        idle();
        chk("stream_cycles", cyc - c0, 1000);
        repeat (3) @(posedge clk);
        #1;
        chk("stream_results", n_got - g0, 1000);
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
